// File: rtl/gpioemu_bus_sync.sv
// Host strobe bus to clk-domain front-end for the GPIO emulator core:
// strobe synchronisers, buffered write FIFO toward the core, and a timed read transaction.
module gpioemu_bus_sync #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] saddress,
  input  logic              srd,
  input  logic              swr,
  input  logic [DATA_W-1:0] sdata_in,
  output logic [DATA_W-1:0] sdata_out,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_timeout,
  output logic [2:0]        fifo_level,
  output logic [7:0]        ovf_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_TIMEOUT);

  typedef enum logic {R_IDLE, R_WAIT} rd_state_e;

  logic              srd_s1_q, srd_s2_q, srd_s3_q, srd_s1_d, srd_s2_d, srd_s3_d;
  logic              swr_s1_q, swr_s2_q, swr_s3_q, swr_s1_d, swr_s2_d, swr_s3_d;
  logic [ADDR_W-1:0] addr_s1_q, addr_s2_q, addr_s1_d, addr_s2_d;
  logic [DATA_W-1:0] data_s1_q, data_s2_q, data_s1_d, data_s2_d;

  logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [7:0]        ovf_q, ovf_d;

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_timeout_q, rd_timeout_d;
  logic [DATA_W-1:0] sdata_out_q, sdata_out_d;

  logic rd_edge, wr_edge, full, push, pop, drop;

  always_comb begin
    srd_s1_d  = srd;
    srd_s2_d  = srd_s1_q;
    srd_s3_d  = srd_s2_q;
    swr_s1_d  = swr;
    swr_s2_d  = swr_s1_q;
    swr_s3_d  = swr_s2_q;
    addr_s1_d = saddress;
    addr_s2_d = addr_s1_q;
    data_s1_d = sdata_in;
    data_s2_d = data_s1_q;

    rd_edge = srd_s2_q & ~srd_s3_q;
    wr_edge = swr_s2_q & ~swr_s3_q;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    full = (level_q == FULL_LVL);
    pop  = (level_q != '0) & wr_ready;
    push = wr_edge & (~full | pop);
    drop = wr_edge & full & ~pop;

    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    ovf_d      = ovf_q;

    if (push) begin
      mem_addr_d[tail_q] = addr_s2_q;
      mem_data_d[tail_q] = data_s2_q;
      tail_d             = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (drop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end

    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_req_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_timeout_d = rd_timeout_q;
    sdata_out_d  = sdata_out_q;

    // Read edges seen in R_WAIT are dropped; the host must not overlap reads.
    case (state_q)
      R_IDLE: begin
        if (rd_edge) begin
          rd_addr_d    = addr_s2_q;
          rd_req_d     = 1'b1;
          rd_timeout_d = 1'b0;
          cnt_d        = CNT_LOAD;
          state_d      = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_valid) begin
          sdata_out_d = rd_data;
          state_d     = R_IDLE;
        end else if (cnt_q == '0) begin
          sdata_out_d  = '0;
          rd_timeout_d = 1'b1;
          state_d      = R_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srd_s1_q     <= 1'b0;
      srd_s2_q     <= 1'b0;
      srd_s3_q     <= 1'b0;
      swr_s1_q     <= 1'b0;
      swr_s2_q     <= 1'b0;
      swr_s3_q     <= 1'b0;
      addr_s1_q    <= '0;
      addr_s2_q    <= '0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      level_q      <= '0;
      ovf_q        <= '0;
      state_q      <= R_IDLE;
      cnt_q        <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_timeout_q <= 1'b0;
      sdata_out_q  <= '0;
    end else begin
      srd_s1_q     <= srd_s1_d;
      srd_s2_q     <= srd_s2_d;
      srd_s3_q     <= srd_s3_d;
      swr_s1_q     <= swr_s1_d;
      swr_s2_q     <= swr_s2_d;
      swr_s3_q     <= swr_s3_d;
      addr_s1_q    <= addr_s1_d;
      addr_s2_q    <= addr_s2_d;
      data_s1_q    <= data_s1_d;
      data_s2_q    <= data_s2_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      level_q      <= level_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      rd_timeout_q <= rd_timeout_d;
      sdata_out_q  <= sdata_out_d;
    end
  end

  assign wr_valid   = (level_q != '0);
  assign wr_addr    = mem_addr_q[head_q];
  assign wr_data    = mem_data_q[head_q];
  assign fifo_level = 3'(level_q);
  assign ovf_count  = ovf_q;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign rd_timeout = rd_timeout_q;
  assign sdata_out  = sdata_out_q;

endmodule

// File: tb/tb_gpioemu_bus_sync.sv
// Randomised bench for gpioemu_bus_sync: host strobe transactions checked against
// a queue-based FIFO model and a latency-rule read model.
module tb_gpioemu_bus_sync;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int RD_TO  = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] saddress;
  logic              srd, swr;
  logic [DATA_W-1:0] sdata_in;
  logic [DATA_W-1:0] sdata_out;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_timeout;
  logic [2:0]        fifo_level;
  logic [7:0]        ovf_count;

  int tests = 0;
  int fails = 0;
  int rdreq_cnt = 0;
  int ovf_m = 0;
  logic [ADDR_W+DATA_W-1:0] q[$];

  gpioemu_bus_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .RD_TIMEOUT(RD_TO)) dut (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_timeout(rd_timeout),
    .fifo_level(fifo_level), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rd_req === 1'b1) rdreq_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required end before 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; srd = 1'b0; swr = 1'b0; wr_ready = 1'b0; rd_valid = 1'b0;
    saddress = '0; sdata_in = '0; rd_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q.delete();
    ovf_m = 0;
  endtask

  // Host write with wr_ready held low; the model applies the push-or-drop rule.
  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk); saddress = a; sdata_in = d;
    @(negedge clk); swr = 1'b1;
    repeat (2) @(negedge clk);
    swr = 1'b0;
    repeat (2) @(negedge clk);
    if (q.size() < DEPTH) q.push_back({a, d});
    else if (ovf_m < 255) ovf_m++;
  endtask

  task automatic drain_fifo(input bit rnd, input int n);
    int popped = 0;
    int budget = 0;
    bit rdy;
    while (popped < n && q.size() > 0 && budget < 200) begin
      @(negedge clk);
      budget++;
      tests++;
      if (fifo_level !== 3'(q.size())) begin
        fails++; $display("FAIL drain_level: got %0d, required %0d", fifo_level, q.size());
      end
      tests++;
      if (wr_valid !== 1'b1) begin
        fails++; $display("FAIL drain_valid: got %b, required 1", wr_valid);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_valid === 1'b1 && rdy) begin
        tests++;
        if ({wr_addr, wr_data} !== q[0]) begin
          fails++; $display("FAIL drain_head: got %h/%h, required %h", wr_addr, wr_data, q[0]);
        end
        void'(q.pop_front());
        popped++;
      end
      wr_ready = rdy;
    end
    @(negedge clk);
    wr_ready = 1'b0;
    if (budget >= 200) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", q.size());
    end
  endtask

  // lat: edge after the rd_req edge that samples rd_valid (0 = never). The model treats
  // 1..RD_TO as answered, no response or a later one as a timeout.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int lat,
                         input logic [DATA_W-1:0] d, input bit restrobe);
    int  c0 = rdreq_cnt;
    bit  good = (lat >= 1 && lat <= RD_TO);
    @(negedge clk); saddress = a;
    @(negedge clk); srd = 1'b1;
    repeat (2) @(negedge clk);
    srd = 1'b0;
    @(negedge clk);
    tests++;
    if (rd_req !== 1'b1 || rd_addr !== a || rd_timeout !== 1'b0) begin
      fails++; $display("FAIL rd_start: got req=%b addr=%h to=%b, required req=1 addr=%h to=0",
                        rd_req, rd_addr, rd_timeout, a);
    end
    for (int k = 1; k <= 24; k++) begin
      if (k == lat) begin rd_valid = 1'b1; rd_data = d; end
      if (restrobe && k == 4) srd = 1'b1;
      if (restrobe && k == 6) srd = 1'b0;
      @(negedge clk);
      rd_valid = 1'b0; rd_data = $urandom;
      if (k == 1) begin
        tests++;
        if (rd_req !== 1'b0) begin
          fails++; $display("FAIL rd_req_width: got %b, required 0", rd_req);
        end
      end
      if (good && k == lat) begin
        tests++;
        if (sdata_out !== d) begin
          fails++; $display("FAIL rd_latency: got %h, required %h", sdata_out, d);
        end
      end
      if (k == RD_TO) begin
        tests++;
        if (rd_timeout !== 1'b0) begin
          fails++; $display("FAIL rd_early_timeout: got %b, required 0", rd_timeout);
        end
      end
      if (k == RD_TO + 1) begin
        tests++;
        if (rd_timeout !== !good) begin
          fails++; $display("FAIL rd_timeout_edge: got %b, required %b", rd_timeout, !good);
        end
      end
    end
    tests++;
    if (sdata_out !== (good ? d : '0) || rd_timeout !== !good || rd_addr !== a) begin
      fails++; $display("FAIL rd_result: got data=%h to=%b addr=%h, required data=%h to=%b addr=%h",
                        sdata_out, rd_timeout, rd_addr, good ? d : '0, !good, a);
    end
    tests++;
    if (rdreq_cnt - c0 !== 1) begin
      fails++; $display("FAIL rd_req_count: got %0d, required 1", rdreq_cnt - c0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; srd = 1'b0; swr = 1'b0; wr_ready = 1'b0; rd_valid = 1'b0;
    saddress = '0; sdata_in = '0; rd_data = '0;
    @(negedge clk);
    tests++;
    if ({sdata_out, wr_valid, wr_addr, wr_data, rd_req, rd_addr, rd_timeout, fifo_level, ovf_count} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({sdata_out, wr_valid, wr_addr, wr_data, rd_req, rd_addr, rd_timeout, fifo_level, ovf_count} !== '0) begin
      fails++; $display("FAIL reset_idle: got nonzero outputs after release, required all 0");
    end
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk); saddress = 16'h037F; sdata_in = 32'h0012_3456;
    @(negedge clk); swr = 1'b1;
    @(negedge clk);
    @(negedge clk); swr = 1'b0;
    tests++;
    if (wr_valid !== 1'b0) begin
      fails++; $display("FAIL wr_latency_early: got %b, required 0", wr_valid);
    end
    @(negedge clk);
    tests++;
    if (wr_valid !== 1'b1 || wr_addr !== 16'h037F || wr_data !== 32'h0012_3456 || fifo_level !== 3'd1) begin
      fails++; $display("FAIL wr_single: got v=%b a=%h d=%h l=%0d, required v=1 a=037f d=00123456 l=1",
                        wr_valid, wr_addr, wr_data, fifo_level);
    end
    wr_ready = 1'b1;
    @(negedge clk); wr_ready = 1'b0;
    tests++;
    if (wr_valid !== 1'b0 || fifo_level !== 3'd0 || ovf_count !== 8'd0) begin
      fails++; $display("FAIL wr_pop: got v=%b l=%0d ovf=%0d, required v=0 l=0 ovf=0",
                        wr_valid, fifo_level, ovf_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) host_write(16'h0388, DATA_W'(i));
    tests++;
    if (fifo_level !== 3'd4 || ovf_count !== 8'd2 || ovf_count !== 8'(ovf_m)) begin
      fails++; $display("FAIL ovf_six: got l=%0d ovf=%0d, required l=4 ovf=2", fifo_level, ovf_count);
    end
    tests++;
    if (q[0][DATA_W-1:0] !== 32'd1 || q[3][DATA_W-1:0] !== 32'd4) begin
      fails++; $display("FAIL ovf_model_order: got %h..%h, required 1..4", q[0], q[3]);
    end
    drain_fifo(1'b0, DEPTH);
    for (int i = 0; i < 304; i++) host_write(16'(i), $urandom);
    tests++;
    if (ovf_count !== 8'd255 || ovf_count !== 8'(ovf_m)) begin
      fails++; $display("FAIL ovf_saturate: got %0d, required 255", ovf_count);
    end
    drain_fifo(1'b1, DEPTH);
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) host_write(16'h0400 + 16'(i), 32'h100 + 32'(i));
    @(negedge clk); saddress = 16'h0405; sdata_in = 32'h105;
    @(negedge clk); swr = 1'b1;
    @(negedge clk);
    @(negedge clk); swr = 1'b0; wr_ready = 1'b1;
    @(negedge clk); wr_ready = 1'b0;
    void'(q.pop_front());
    q.push_back({16'h0405, 32'h105});
    tests++;
    if (fifo_level !== 3'd4 || ovf_count !== 8'd0 || {wr_addr, wr_data} !== q[0]) begin
      fails++; $display("FAIL full_pop: got l=%0d ovf=%0d head=%h/%h, required l=4 ovf=0 head=%h",
                        fifo_level, ovf_count, wr_addr, wr_data, q[0]);
    end
    drain_fifo(1'b0, 2);
    host_write(16'h0406, 32'h106);
    host_write(16'h0407, 32'h107);
    drain_fifo(1'b1, 2);
    for (int i = 8; i <= 10; i++) host_write(16'h0400 + 16'(i), 32'h100 + 32'(i));
    tests++;
    if (fifo_level !== 3'd4 || ovf_count !== 8'(ovf_m)) begin
      fails++; $display("FAIL wrap_level: got l=%0d ovf=%0d, required l=4 ovf=%0d", fifo_level, ovf_count, ovf_m);
    end
    drain_fifo(1'b1, DEPTH);
  endtask

  task automatic test_random_writes();
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int i = 0; i < int'($urandom_range(1, 7)); i++) host_write(16'($urandom), $urandom);
      tests++;
      if (fifo_level !== 3'(q.size()) || ovf_count !== 8'(ovf_m)) begin
        fails++; $display("FAIL rand_fill: got l=%0d ovf=%0d, required l=%0d ovf=%0d",
                          fifo_level, ovf_count, q.size(), ovf_m);
      end
      drain_fifo(1'b1, DEPTH);
      wr_ready = 1'b1;
      repeat (2) @(negedge clk);
      wr_ready = 1'b0;
      tests++;
      if (fifo_level !== 3'd0 || wr_valid !== 1'b0) begin
        fails++; $display("FAIL empty_ready: got l=%0d v=%b, required l=0 v=0", fifo_level, wr_valid);
      end
    end
  endtask

  task automatic test_read();
    do_reset();
    do_read(16'h0390, 3, 32'hCAFE_F00D, 1'b0);
    repeat (5) @(negedge clk);
    tests++;
    if (sdata_out !== 32'hCAFE_F00D || rd_timeout !== 1'b0) begin
      fails++; $display("FAIL rd_hold: got %h to=%b, required cafef00d to=0", sdata_out, rd_timeout);
    end
  endtask

  task automatic test_timeout_rearm();
    do_read(16'h03A0, 0, 32'h0, 1'b0);
    do_read(16'h03A4, 0, 32'h0, 1'b1);
    do_read(16'h03B0, 2, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_random_reads();
    int lat;
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0:       lat = $urandom_range(1, RD_TO);
        1:       lat = $urandom_range(RD_TO + 3, 22);
        default: lat = 0;
      endcase
      do_read(16'($urandom), lat, $urandom, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset();
    for (int i = 0; i < 3; i++) host_write(16'h0500 + 16'(i), $urandom);
    @(negedge clk); saddress = 16'h03C0;
    @(negedge clk); srd = 1'b1;
    repeat (2) @(negedge clk);
    srd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (fifo_level !== 3'd3 || rd_addr !== 16'h03C0) begin
      fails++; $display("FAIL mid_pre: got l=%0d addr=%h, required l=3 addr=03c0", fifo_level, rd_addr);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({sdata_out, wr_valid, wr_addr, wr_data, rd_req, rd_addr, rd_timeout, fifo_level, ovf_count} !== '0) begin
      fails++; $display("FAIL mid_async_reset: got l=%0d v=%b addr=%h, required all 0", fifo_level, wr_valid, rd_addr);
    end
    @(negedge clk); reset = 1'b0;
    q.delete(); ovf_m = 0;
    c0 = rdreq_cnt;
    @(negedge clk); rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
    @(negedge clk); rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (sdata_out !== '0 || rdreq_cnt !== c0 || fifo_level !== 3'd0) begin
      fails++; $display("FAIL mid_after: got data=%h req=%0d l=%0d, required data=0 req=0 l=0",
                        sdata_out, rdreq_cnt - c0, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_full_pop();
    test_random_writes();
    test_read();
    test_timeout_rearm();
    test_random_reads();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpioemu_bus_sync.md
# gpioemu_bus_sync

Clock-domain front-end between the asynchronous host strobe bus (saddress/srd/swr/sdata_in/sdata_out) and the clocked GPIO emulator core. Synchronises srd/swr into clk, turns each strobe rising edge into one request, buffers writes in a small FIFO with a valid/ready handshake toward the core, and runs a read transaction whose response is held on sdata_out for the host. Every register access to the core passes through this block.

## Interface
Parameters:
- ADDR_W, 16, host address width
- DATA_W, 32, data width
- FIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)
- RD_TIMEOUT, 15, clk cycles to wait for a core read response

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- saddress  in  ADDR_W  host address (asynchronous)
- srd  in  1  host read strobe (asynchronous)
- swr  in  1  host write strobe (asynchronous)
- sdata_in  in  DATA_W  host write data (asynchronous)
- sdata_out  out  DATA_W  read data held for host
- wr_valid  out  1  FIFO head valid toward core
- wr_ready  in  1  core accepts head this cycle
- wr_addr  out  ADDR_W  FIFO head address
- wr_data  out  DATA_W  FIFO head data
- rd_req  out  1  one-cycle read request pulse
- rd_addr  out  ADDR_W  read address, held through the read
- rd_valid  in  1  core read data valid
- rd_data  in  DATA_W  core read data
- rd_timeout  out  1  last read ended by timeout (sticky until next read)
- fifo_level  out  3  current FIFO occupancy (0..FIFO_DEPTH)
- ovf_count  out  8  dropped writes, saturating at 255

## Operation
- Host bus rules: each strobe high ≥2 clk and low ≥2 clk. saddress/sdata_in stable from 1 clk before strobe rise until strobe fall. srd and swr never high together.
- srd, swr, saddress, sdata_in each pass through a 2-FF synchroniser (s1, s2), plus a third stage s3 on the strobes. Edge = s2 & ~s3. Address/data are captured from the s2 copies.
- Write edge: push {addr, data} if FIFO not full, or if full and pop occurs in the same cycle. Otherwise drop it and increment ovf_count (saturates at 255, no wrap).
- FIFO is a circular buffer with wrap-around pointers:
  - wr_valid = level≠0; wr_addr/wr_data show the head.
  - Pop when wr_valid & wr_ready. wr_ready while empty is ignored.
  - Simultaneous push and pop leaves level unchanged.
- Read FSM:
  - R_IDLE: on read edge, latch rd_addr, pulse rd_req for 1 cycle, clear rd_timeout, load counter = RD_TIMEOUT, go R_WAIT.
  - R_WAIT:
    - rd_valid → sdata_out <= rd_data, go R_IDLE.
    - Counter reaches 0 first → sdata_out <= 0, rd_timeout <= 1, go R_IDLE.
    - Counter decrements every cycle.
    - A read edge while in R_WAIT is ignored (no queueing).
  - rd_valid outside R_WAIT is ignored.
- Reads and writes are independent. A read does not wait for the FIFO to drain; ordering is the host's responsibility.
- Reset values: sdata_out=0, wr_valid=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, rd_timeout=0, fifo_level=0, ovf_count=0. All sync flops are 0 and the FSM is R_IDLE.
- Reset mid-operation discards FIFO contents and any pending read. A strobe that is still high when reset releases produces an edge once s2 rises (s3 is reset low).

## Timing
- Strobe first sampled high at clk edge N. s2=1 after N+1, edge active during cycle N+1→N+2, and the push/rd_req register takes effect at N+2.
  - Write: wr_valid=1 visible after edge N+2 (empty FIFO).
  - Read: rd_req high for exactly the cycle after N+2.
- Pop: head advances on the edge where wr_valid & wr_ready; next entry is visible the following cycle. Sustained throughput is one pop per cycle.
- Read response: sdata_out updates on the edge sampling rd_valid=1. Minimum latency is 1 cycle after rd_req.
- Timeout: with no rd_valid, sdata_out=0 and rd_timeout=1 on the (RD_TIMEOUT+1)th edge after the rd_req edge.
- Outputs are registered; no combinational path from asynchronous host inputs to any output.

## Test plan
- Reset then single write: swr with saddress=0x037F, sdata_in=0x00123456, wr_ready=0 → wr_valid=1 three edges after first sampling; wr_addr=0x037F, wr_data=0x00123456, fifo_level=1; raising wr_ready for 1 cycle → wr_valid=0.
- Overflow: 6 writes to 0x0388 (data 1..6) with wr_ready=0 → fifo_level=4, ovf_count=2; draining yields data 1,2,3,4 in order. Continue to 300 drops → ovf_count stays 255.
- Full with simultaneous pop: FIFO full, wr_ready=1 held in the same cycle as the 5th write's push → no drop, fifo_level stays 4, ovf_count unchanged; pointer wrap-around yields correct order over 10 writes.
- Read: srd at saddress=0x0390, core returns rd_data=0xCAFEF00D 3 cycles after rd_req → rd_req is a single cycle, rd_addr=0x0390, sdata_out=0xCAFEF00D and held until the next read, rd_timeout=0.
- Read timeout and re-arm: srd at 0x03A0, no rd_valid → sdata_out=0, rd_timeout=1 after 16 edges. A second srd in R_WAIT during another read produces no second rd_req. A subsequent good read clears rd_timeout.
- Reset mid-operation: 3 entries queued and read in R_WAIT, assert reset asynchronously between edges → all outputs 0 immediately. After release, rd_valid=1 has no effect on sdata_out.
